// File: rtl/pll_reset_sequencer_if.sv
// ============================================================================
//  Module   : pll_reset_sequencer_if
//  Brief    : PLL-side and system-side signals of the PLL reset sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [7:0] lock_loss_count;

  // The sequencer drives PLL reset and system status.
  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst,
    output ready,
    output fault,
    output lock_loss_count
  );

  // The PLL / system side observes status and supplies lock.
  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  fault,
    input  lock_loss_count
  );
endinterface

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
//  Module   : pll_reset_sequencer
//  Brief    : PLL power-up / lock-supervision sequencer on the reference clock.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned MAX_RETRIES    = 4
) (
  input  wire logic              refclk,
  input  wire logic              rst,
  pll_reset_sequencer_if.master  bus
);

  localparam int unsigned C_MAX_A = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned C_MAX_P = (C_MAX_A > LOCK_TIMEOUT) ? C_MAX_A : LOCK_TIMEOUT;
  localparam int          CNT_W   = $clog2(C_MAX_P) + 1;

  localparam logic [CNT_W-1:0] C_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]       C_RETRIES  = 8'(MAX_RETRIES);

  localparam logic [2:0] S_PLL_RESET = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABILIZE = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             lock_meta_q, lock_s_q;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  // State register, counters, lock synchronizer and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_PLL_RESET;
      cnt_q       <= '0;
      retry_q     <= 8'd0;
      loss_q      <= 8'd0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      lock_meta_q <= bus.pll_locked;
      lock_s_q    <= lock_meta_q;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state logic; lock events take priority over counter expiry.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      S_PLL_RESET: begin
        if (cnt_q == C_RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_STABILIZE;
        end else if (cnt_q == C_TO_LAST) begin
          retry_d = retry_q + 8'd1;
          state_d = (retry_d == C_RETRIES) ? S_FAULT : S_PLL_RESET;
        end
      end
      S_STABILIZE: begin
        if (!lock_s_q) begin
          state_d = S_PLL_RESET;
        end else if (cnt_q == C_STB_LAST) begin
          state_d = S_RUN;
          retry_d = 8'd0;
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d = S_PLL_RESET;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_PLL_RESET;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Outputs decoded from the next state so they move with the state register.
  always_comb begin
    pll_rst_d = (state_d == S_PLL_RESET) || (state_d == S_FAULT);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
  end

  assign bus.pll_rst         = pll_rst_q;
  assign bus.sys_rst         = sys_rst_q;
  assign bus.ready           = ready_q;
  assign bus.fault           = fault_q;
  assign bus.lock_loss_count = loss_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
//  Module   : tb_pll_reset_sequencer
//  Brief    : Directed self-checking bench for pll_reset_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pll_reset_sequencer;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .STABLE_CYCLES (8),
    .LOCK_TIMEOUT  (32),
    .MAX_RETRIES   (3)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  always #10 refclk = ~refclk;

  // Cycle k is the k-th rising edge after rst release; sampling is 1 ns later.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_to(input int k);
    tick(k - cyc);
  endtask

  task automatic do_reset(input logic lock);
    bus.pll_locked = lock;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset;
    bus.pll_locked = 1'b0;
    rst = 1'b1;
    tick(3);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst got=%b exp=1", bus.pll_rst); end
    checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL reset_sys_rst got=%b exp=1", bus.sys_rst); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", bus.fault); end
    checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("FAIL reset_llc got=%0d exp=0", bus.lock_loss_count); end
  endtask

  task automatic test_power_up;
    do_reset(1'b1);
    run_to(1);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL pu_pll_rst_c1 got=%b exp=1", bus.pll_rst); end
    run_to(3);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL pu_pll_rst_c3 got=%b exp=1", bus.pll_rst); end
    run_to(4);
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL pu_pll_rst_c4 got=%b exp=0", bus.pll_rst); end
    run_to(12);
    checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL pu_sys_rst_c12 got=%b exp=1", bus.sys_rst); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL pu_ready_c12 got=%b exp=0", bus.ready); end
    run_to(13);
    checks++; if (bus.sys_rst !== 1'b0) begin errors++; $display("FAIL pu_sys_rst_c13 got=%b exp=0", bus.sys_rst); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL pu_ready_c13 got=%b exp=1", bus.ready); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL pu_fault got=%b exp=0", bus.fault); end
    checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("FAIL pu_llc got=%0d exp=0", bus.lock_loss_count); end
  endtask

  task automatic test_glitch;
    do_reset(1'b1);
    run_to(8);
    bus.pll_locked = 1'b0;
    run_to(10);
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL gl_pll_rst_c10 got=%b exp=0", bus.pll_rst); end
    run_to(11);
    bus.pll_locked = 1'b1;
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL gl_pll_rst_c11 got=%b exp=1", bus.pll_rst); end
    checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL gl_sys_rst_c11 got=%b exp=1", bus.sys_rst); end
    run_to(14);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL gl_pll_rst_c14 got=%b exp=1", bus.pll_rst); end
    run_to(15);
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL gl_pll_rst_c15 got=%b exp=0", bus.pll_rst); end
    run_to(23);
    checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL gl_sys_rst_c23 got=%b exp=1", bus.sys_rst); end
    run_to(24);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL gl_ready_c24 got=%b exp=1", bus.ready); end
    checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("FAIL gl_llc got=%0d exp=0", bus.lock_loss_count); end
  endtask

  task automatic test_lock_loss;
    do_reset(1'b1);
    run_to(19);
    bus.pll_locked = 1'b0;
    run_to(21);
    checks++; if (bus.sys_rst !== 1'b0) begin errors++; $display("FAIL ll_sys_rst_c21 got=%b exp=0", bus.sys_rst); end
    run_to(22);
    bus.pll_locked = 1'b1;
    checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL ll_sys_rst_c22 got=%b exp=1", bus.sys_rst); end
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL ll_pll_rst_c22 got=%b exp=1", bus.pll_rst); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL ll_ready_c22 got=%b exp=0", bus.ready); end
    checks++; if (bus.lock_loss_count !== 8'd1) begin errors++; $display("FAIL ll_llc got=%0d exp=1", bus.lock_loss_count); end
    run_to(34);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL ll_ready_c34 got=%b exp=0", bus.ready); end
    run_to(35);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL ll_ready_c35 got=%b exp=1", bus.ready); end
    checks++; if (bus.lock_loss_count !== 8'd1) begin errors++; $display("FAIL ll_llc_c35 got=%0d exp=1", bus.lock_loss_count); end
  endtask

  task automatic test_timeout_fault;
    do_reset(1'b0);
    run_to(35);
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL to_pll_rst_c35 got=%b exp=0", bus.pll_rst); end
    run_to(36);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL to_pll_rst_c36 got=%b exp=1", bus.pll_rst); end
    run_to(39);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL to_pll_rst_c39 got=%b exp=1", bus.pll_rst); end
    run_to(40);
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL to_pll_rst_c40 got=%b exp=0", bus.pll_rst); end
    run_to(72);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL to_pll_rst_c72 got=%b exp=1", bus.pll_rst); end
    run_to(76);
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL to_pll_rst_c76 got=%b exp=0", bus.pll_rst); end
    run_to(107);
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL to_fault_c107 got=%b exp=0", bus.fault); end
    run_to(108);
    checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL to_fault_c108 got=%b exp=1", bus.fault); end
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL to_pll_rst_c108 got=%b exp=1", bus.pll_rst); end
    bus.pll_locked = 1'b1;
    tick(20);
    checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL flt_sticky got=%b exp=1", bus.fault); end
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL flt_pll_rst got=%b exp=1", bus.pll_rst); end
    checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL flt_sys_rst got=%b exp=1", bus.sys_rst); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL flt_ready got=%b exp=0", bus.ready); end
    rst = 1'b1;
    tick(1);
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL flt_rst_fault got=%b exp=0", bus.fault); end
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL flt_rst_pll_rst got=%b exp=1", bus.pll_rst); end
    rst = 1'b0;
    cyc = 0;
    run_to(13);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL flt_rerun_ready got=%b exp=1", bus.ready); end
  endtask

  task automatic test_saturation;
    int exp_llc;
    do_reset(1'b1);
    run_to(13);
    for (int i = 1; i <= 260; i++) begin
      exp_llc = (i > 255) ? 255 : i;
      bus.pll_locked = 1'b0;
      tick(3);
      checks++; if (bus.pll_rst !== 1'b1 || bus.sys_rst !== 1'b1) begin errors++; $display("FAIL sat_loss_%0d pll_rst=%b sys_rst=%b exp=1,1", i, bus.pll_rst, bus.sys_rst); end
      checks++; if (bus.lock_loss_count !== 8'(exp_llc)) begin errors++; $display("FAIL sat_llc_%0d got=%0d exp=%0d", i, bus.lock_loss_count, exp_llc); end
      bus.pll_locked = 1'b1;
      tick(13);
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL sat_ready_%0d got=%b exp=1", i, bus.ready); end
    end
  endtask

  task automatic test_reset_mid;
    bus.pll_locked = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL mid_run_sys_rst got=%b exp=1", bus.sys_rst); end
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL mid_run_pll_rst got=%b exp=1", bus.pll_rst); end
    checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("FAIL mid_run_llc got=%0d exp=0", bus.lock_loss_count); end
    rst = 1'b0;
    cyc = 0;
    run_to(12);
    checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL mid_run_c12 got=%b exp=1", bus.sys_rst); end
    run_to(13);
    checks++; if (bus.sys_rst !== 1'b0) begin errors++; $display("FAIL mid_run_c13 got=%b exp=0", bus.sys_rst); end
    do_reset(1'b1);
    run_to(8);
    rst = 1'b1;
    tick(1);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL mid_stb_pll_rst got=%b exp=1", bus.pll_rst); end
    checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL mid_stb_sys_rst got=%b exp=1", bus.sys_rst); end
    rst = 1'b0;
    cyc = 0;
    run_to(4);
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL mid_stb_c4 got=%b exp=0", bus.pll_rst); end
    run_to(12);
    checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL mid_stb_c12 got=%b exp=1", bus.sys_rst); end
    run_to(13);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL mid_stb_c13 got=%b exp=1", bus.ready); end
  endtask

  initial begin
    bus.pll_locked = 1'b0;
    test_reset();
    test_power_up();
    test_glitch();
    test_lock_loss();
    test_timeout_fault();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
